// File: rtl/ota_cloop_sched.sv
// Round-robin scheduler that time-shares one closed-loop OTA between N requesters,
// sequencing power-up, per-grant settling, a single sample strobe and idle power-down.
module ota_cloop_sched #(
  parameter int N   = 4,
  parameter int FFW = 4,
  parameter int CW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*FFW-1:0]     ff_cfg,
  input  logic [CW-1:0]        wake_cyc,
  input  logic [CW-1:0]        settle_cyc,
  input  logic [CW-1:0]        idle_cyc,
  output logic                 pd,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] ch_sel,
  output logic [FFW-1:0]       ff_code,
  output logic                 sample,
  output logic                 busy
);

  localparam int SW = $clog2(N);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_WAKE   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_GAP    = 3'd4,
    S_IDLE   = 3'd5
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx, cnt_dec;
  logic [SW-1:0]  ptr, ptr_nx;
  logic [N-1:0]   gnt_nx, gnt_win;
  logic [SW-1:0]  ch_sel_nx, win, ptr_win;
  logic [FFW-1:0] ff_nx, ff_win;
  logic           pd_nx, busy_nx, sample_nx;
  logic           do_grant, go_idle;
  logic [CW-1:0]  wake_ld, settle_ld;

  // First requesting channel at or after p, wrapping N-1 -> 0; the lowest offset wins.
  function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] r, input logic [SW-1:0] p);
    int j;
    logic [SW-1:0] pick;
    pick = p;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (r[j]) begin
        pick = SW'(j);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Arbitration result and counter reload values, used only on a grant/load edge.
  always_comb begin
    win       = rr_pick(req, ptr);
    ptr_win   = (win == SW'(N - 1)) ? {SW{1'b0}} : win + SW'(1);
    gnt_win   = {{(N-1){1'b0}}, 1'b1} << win;
    ff_win    = ff_cfg[int'(win)*FFW +: FFW];
    wake_ld   = (wake_cyc   == {CW{1'b0}}) ? CW'(1) : wake_cyc;
    settle_ld = (settle_cyc == {CW{1'b0}}) ? CW'(1) : settle_cyc;
    cnt_dec   = cnt - CW'(1);
  end

  // Next-state and next-output logic; every output register is computed here.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ptr_nx    = ptr;
    gnt_nx    = gnt;
    ch_sel_nx = ch_sel;
    ff_nx     = ff_code;
    do_grant  = 1'b0;
    go_idle   = 1'b0;

    case (state)
      S_OFF: begin
        if (|req) begin
          state_nx = S_WAKE;
          cnt_nx   = wake_ld;
        end else begin
          state_nx = S_OFF;
        end
      end
      S_WAKE: begin
        if (!(|req)) begin
          go_idle = 1'b1;
        end else if (cnt <= CW'(1)) begin
          do_grant = 1'b1;
        end else begin
          cnt_nx = cnt_dec;
        end
      end
      S_SETTLE: begin
        // A requester that gives up mid-settle forfeits its slot; pointer already moved.
        if (!req[ch_sel]) begin
          state_nx = S_GAP;
          gnt_nx   = {N{1'b0}};
        end else if (cnt <= CW'(1)) begin
          state_nx = S_SAMPLE;
        end else begin
          cnt_nx = cnt_dec;
        end
      end
      S_SAMPLE: begin
        state_nx = S_GAP;
        gnt_nx   = {N{1'b0}};
      end
      S_GAP: begin
        if (|req) begin
          do_grant = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end
      S_IDLE: begin
        // A new request beats an expiring idle count.
        if (|req) begin
          do_grant = 1'b1;
        end else if (cnt <= CW'(1)) begin
          state_nx = S_OFF;
        end else begin
          cnt_nx = cnt_dec;
        end
      end
      default: begin
        state_nx = S_OFF;
        gnt_nx   = {N{1'b0}};
      end
    endcase

    if (do_grant) begin
      state_nx  = S_SETTLE;
      cnt_nx    = settle_ld;
      gnt_nx    = gnt_win;
      ch_sel_nx = win;
      ff_nx     = ff_win;
      ptr_nx    = ptr_win;
    end else if (go_idle) begin
      if (idle_cyc == {CW{1'b0}}) begin
        state_nx = S_OFF;
      end else begin
        state_nx = S_IDLE;
        cnt_nx   = idle_cyc;
      end
    end else begin
      cnt_nx = cnt_nx;
    end

    pd_nx     = (state_nx == S_OFF);
    busy_nx   = (state_nx != S_OFF);
    sample_nx = (state_nx == S_SAMPLE);
  end

  // State, counter, pointer and all output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_OFF;
      cnt     <= {CW{1'b0}};
      ptr     <= {SW{1'b0}};
      pd      <= 1'b1;
      gnt     <= {N{1'b0}};
      ch_sel  <= {SW{1'b0}};
      ff_code <= {FFW{1'b0}};
      sample  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ptr     <= ptr_nx;
      pd      <= pd_nx;
      gnt     <= gnt_nx;
      ch_sel  <= ch_sel_nx;
      ff_code <= ff_nx;
      sample  <= sample_nx;
      busy    <= busy_nx;
    end
  end

endmodule

// File: tb/tb_ota_cloop_sched.sv
// Directed bench for ota_cloop_sched: cycle-exact vectors with hand-computed expectations.
module tb_ota_cloop_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] ff_cfg;
  logic [7:0]  wake_cyc;
  logic [7:0]  settle_cyc;
  logic [7:0]  idle_cyc;
  logic        pd;
  logic [3:0]  gnt;
  logic [1:0]  ch_sel;
  logic [3:0]  ff_code;
  logic        sample;
  logic        busy;

  int n_chk;
  int n_fail;
  logic [3:0] expg;

  ota_cloop_sched #(.N(4), .FFW(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .ff_cfg(ff_cfg),
    .wake_cyc(wake_cyc), .settle_cyc(settle_cyc), .idle_cyc(idle_cyc),
    .pd(pd), .gnt(gnt), .ch_sel(ch_sel), .ff_code(ff_code),
    .sample(sample), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pd"},     32'(pd),      32'd1);
    check({tag, "_gnt"},    32'(gnt),     32'd0);
    check({tag, "_ch_sel"}, 32'(ch_sel),  32'd0);
    check({tag, "_ff"},     32'(ff_code), 32'd0);
    check({tag, "_sample"}, 32'(sample),  32'd0);
    check({tag, "_busy"},   32'(busy),    32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req        = 4'b0000;
    ff_cfg     = 16'hDCBA;
    wake_cyc   = 8'd3;
    settle_cyc = 8'd5;
    idle_cyc   = 8'd4;
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // Test 1: single request from OFF, wake 3 / settle 5 / idle 4
    req = 4'b0001;
    tick();
    check("t1_pd_e0", 32'(pd), 32'd0);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_gnt_e0", 32'(gnt), 32'd0);
    tick();
    tick();
    check("t1_gnt_e2", 32'(gnt), 32'd0);
    tick();
    check("t1_gnt_e3", 32'(gnt), 32'h1);
    check("t1_ch_e3", 32'(ch_sel), 32'd0);
    check("t1_ff_e3", 32'(ff_code), 32'hA);
    check("t1_smp_e3", 32'(sample), 32'd0);
    for (int i = 4; i <= 7; i++) begin
      tick();
      check("t1_nosample", 32'(sample), 32'd0);
    end
    tick();
    check("t1_smp_e8", 32'(sample), 32'd1);
    check("t1_gnt_e8", 32'(gnt), 32'h1);
    check("t1_pd_e8", 32'(pd), 32'd0);
    req = 4'b0000;
    tick();
    check("t1_gnt_e9", 32'(gnt), 32'd0);
    check("t1_smp_e9", 32'(sample), 32'd0);
    for (int i = 10; i <= 13; i++) begin
      tick();
      check("t1_idle_pd", 32'(pd), 32'd0);
    end
    tick();
    check("t1_pd_e14", 32'(pd), 32'd1);
    check("t1_busy_e14", 32'(busy), 32'd0);

    // Test 2: all four requesting, settle 2 -> rotation 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle_cyc = 8'd2;
    req = 4'b1111;
    tick();
    tick();
    tick();
    tick();
    for (int g = 0; g < 5; g++) begin
      expg = 4'b0001 << (g % 4);
      check("t2_gnt", 32'(gnt), 32'(expg));
      check("t2_ch", 32'(ch_sel), 32'(g % 4));
      tick();
      check("t2_settle_smp", 32'(sample), 32'd0);
      check("t2_settle_gnt", 32'(gnt), 32'(expg));
      tick();
      check("t2_smp", 32'(sample), 32'd1);
      if (g == 4) begin
        req = 4'b0000;
      end
      tick();
      check("t2_gap_gnt", 32'(gnt), 32'd0);
      check("t2_gap_pd", 32'(pd), 32'd0);
      tick();
    end

    // Test 3: requester drops during SETTLE -> abort, pointer still advanced
    req = 4'b0100;
    tick();
    check("t3_gnt", 32'(gnt), 32'h4);
    check("t3_ch", 32'(ch_sel), 32'd2);
    check("t3_ff", 32'(ff_code), 32'hC);
    req = 4'b0000;
    tick();
    check("t3_abort_gnt", 32'(gnt), 32'd0);
    check("t3_abort_smp", 32'(sample), 32'd0);
    check("t3_ff_held", 32'(ff_code), 32'hC);
    tick();
    check("t3_idle_smp", 32'(sample), 32'd0);
    check("t3_idle_pd", 32'(pd), 32'd0);
    req = 4'b1001;
    tick();
    check("t3_ptr_gnt", 32'(gnt), 32'h8);
    tick();
    tick();
    check("t3_ch3_smp", 32'(sample), 32'd1);
    req = 4'b0000;
    tick();
    tick();

    // Test 4: request arrives during IDLE -> grant next edge, no WAKE
    tick();
    tick();
    req = 4'b0010;
    ff_cfg = 16'hDCBA;
    tick();
    check("t4_gnt", 32'(gnt), 32'h2);
    check("t4_ch", 32'(ch_sel), 32'd1);
    check("t4_ff", 32'(ff_code), 32'hB);
    ff_cfg = 16'h0000;
    tick();
    check("t4_smp_early", 32'(sample), 32'd0);
    check("t4_ff_latched", 32'(ff_code), 32'hB);
    tick();
    check("t4_smp", 32'(sample), 32'd1);
    req = 4'b0000;
    ff_cfg = 16'hDCBA;
    tick();
    tick();
    idle_cyc = 8'd0;
    tick();
    tick();
    tick();
    check("t4_idle_held_pd", 32'(pd), 32'd0);
    tick();
    check("t4_idle_expire_pd", 32'(pd), 32'd1);

    // Test 5: all timers zero -> 1-cycle WAKE and SETTLE, GAP straight to OFF
    wake_cyc = 8'd0;
    settle_cyc = 8'd0;
    req = 4'b0001;
    tick();
    check("t5_pd_e0", 32'(pd), 32'd0);
    check("t5_gnt_e0", 32'(gnt), 32'd0);
    tick();
    check("t5_gnt_e1", 32'(gnt), 32'h1);
    tick();
    check("t5_smp_e2", 32'(sample), 32'd1);
    req = 4'b0000;
    tick();
    check("t5_gap_gnt", 32'(gnt), 32'd0);
    check("t5_gap_pd", 32'(pd), 32'd0);
    tick();
    check("t5_off_pd", 32'(pd), 32'd1);
    check("t5_off_busy", 32'(busy), 32'd0);

    // Test 6: asynchronous reset during SETTLE, then restart with pointer at 0
    wake_cyc = 8'd3;
    settle_cyc = 8'd5;
    idle_cyc = 8'd4;
    req = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    check("t6_pre_gnt", 32'(gnt), 32'h4);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t6_async");
    req = 4'b1001;
    tick();
    check("t6_rst_smp", 32'(sample), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_pd_e0", 32'(pd), 32'd0);
    check("t6_gnt_e0", 32'(gnt), 32'd0);
    tick();
    tick();
    tick();
    check("t6_gnt_e3", 32'(gnt), 32'h1);
    for (int i = 4; i <= 7; i++) begin
      tick();
      check("t6_nosample", 32'(sample), 32'd0);
    end
    tick();
    check("t6_smp_e8", 32'(sample), 32'd1);
    req = 4'b0000;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
